// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file write-back constants
package rf_pkg;

    localparam int RF_AW    = 4;
    localparam int RF_DW    = 32;
    localparam int RF_NREGS = 16;
    localparam int RF_NREQ  = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_DBG  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o
);

    // Scan ptr, ptr+1, ... wrapping at NREQ; first requester found wins.
    always_comb begin
        int   idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx[IW-1:0]]) begin
                found                = 1'b1;
                grant_o[idx[IW-1:0]] = 1'b1;
                grant_idx_o          = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - write-back arbiter and pending-write scoreboard
module regfile_wb_sched
    import rf_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    output logic                 issue_ready,
    input  logic [AW-1:0]        chk_addr1,
    input  logic [AW-1:0]        chk_addr2,
    output logic                 chk_busy,
    output logic [(2**AW)-1:0]   busy_vec
);

    localparam int NREGS = 2 ** AW;
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [DW-1:0]    rf_wdata_q;
    logic [NREGS-1:0] busy_q, busy_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Any valid requester is always granted, so a transfer happens whenever one is valid.
    assign xfer      = |req_valid;
    assign req_ready = grant;

    // Select the granted requester's address and data for the write port.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Pointer moves just past the winner; holds when nothing transfers.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Scoreboard: clear on write-back, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    // State registers; address and data hold their last value when no write occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= xfer;
            busy_q  <= busy_d;
            if (xfer) begin
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
            end
        end
    end

    assign issue_ready = !busy_q[issue_addr];
    assign chk_busy    = busy_q[chk_addr1] | busy_q[chk_addr2];
    assign busy_vec    = busy_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;

endmodule
